// File: rtl/v3_peak_controller.sv
// -----------------------------------------------------------------------------
// v3_peak_controller
//
// Supervises the v3 pulse-shaping filter and extracts one peak per pulse.
// A flush/settle sequence resets the filter, then the block arms and waits for
// the filter output to cross a signed threshold. It tracks the running maximum
// until the first sample below it, then offers the peak on a valid/ready
// handshake and enforces a dead-time before re-arming. A pulse that keeps
// rising for MAX_RISE cycles is counted as pile-up, and the filter is flushed.
//
// Ports
//   clk            : clock, rising edge
//   reset          : asynchronous active-high reset
//   enable         : allows triggering while in ARMED
//   threshold      : signed trigger level
//   filter_data    : signed filter output sample
//   filter_reset_n : active-low reset to the filter (low in FLUSH)
//   peak_data      : captured peak amplitude (valid with peak_valid)
//   peak_time      : timestamp of the peak sample (valid with peak_valid)
//   peak_valid     : peak offered to the consumer
//   peak_ready     : consumer accepts the peak
//   pileup_count   : saturating count of rejected (pile-up) pulses
//   busy           : high in every state except ARMED
// -----------------------------------------------------------------------------
module v3_peak_controller #(
    parameter int SIZE_ADC_DATA = 12,
    parameter int FLUSH_LEN     = 4,
    parameter int SETTLE_LEN    = 8,
    parameter int MAX_RISE      = 64,
    parameter int HOLDOFF_LEN   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [SIZE_ADC_DATA-1:0] threshold,
    input  logic [SIZE_ADC_DATA-1:0] filter_data,
    output logic                     filter_reset_n,
    output logic [SIZE_ADC_DATA-1:0] peak_data,
    output logic [15:0]              peak_time,
    output logic                     peak_valid,
    input  logic                     peak_ready,
    output logic [15:0]              pileup_count,
    output logic                     busy
);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_SETTLE,
        S_ARMED,
        S_RISE,
        S_EMIT,
        S_HOLDOFF
    } state_t;

    // One phase counter is shared by every timed state; it restarts at zero
    // on each state entry. All length parameters must fit in 16 bits.
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_LEN - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);
    localparam logic [CNT_W-1:0] RISE_LAST   = CNT_W'(MAX_RISE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLDOFF_LEN - 1);

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          cnt, cnt_nxt;
    logic [15:0]               timestamp;
    logic [SIZE_ADC_DATA-1:0]  max_nxt;
    logic [15:0]               max_time_nxt;
    logic [15:0]               pileup_nxt;

    // All amplitude comparisons are full-width signed.
    logic signed [SIZE_ADC_DATA-1:0] sample_s, thr_s, max_s;
    logic                            above_thr;

    assign sample_s  = $signed(filter_data);
    assign thr_s     = $signed(threshold);
    assign max_s     = $signed(peak_data);
    assign above_thr = sample_s > thr_s;

    // Next-state and datapath decisions.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        state_nxt    = state;
        cnt_nxt      = cnt + 1'b1;
        max_nxt      = peak_data;
        max_time_nxt = peak_time;
        pileup_nxt   = pileup_count;

        case (state)
            S_FLUSH: begin
                if (cnt == FLUSH_LAST) begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_nxt = S_ARMED;
                    cnt_nxt   = '0;
                end
            end
            S_ARMED: begin
                cnt_nxt = '0;
                if (enable && above_thr) begin
                    state_nxt    = S_RISE;
                    max_nxt      = filter_data;
                    max_time_nxt = timestamp;
                end
            end
            S_RISE: begin
                // A drop below the running max wins over the pile-up limit:
                // the peak was found on that very cycle.
                if (sample_s < max_s) begin
                    state_nxt = S_EMIT;
                    cnt_nxt   = '0;
                end else if (cnt == RISE_LAST) begin
                    state_nxt = S_FLUSH;
                    cnt_nxt   = '0;
                    if (pileup_count != 16'hFFFF) begin
                        pileup_nxt = pileup_count + 16'd1;
                    end
                end else if (sample_s > max_s) begin
                    max_nxt      = filter_data;
                    max_time_nxt = timestamp;
                end
            end
            S_EMIT: begin
                // No timeout and filter_data ignored: the peak waits for ready.
                cnt_nxt = '0;
                if (peak_ready) begin
                    state_nxt = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                // The counter parks at its last value once dead-time has
                // elapsed; re-arm only when the pulse tail is back below
                // threshold.
                if (cnt == HOLD_LAST) begin
                    cnt_nxt = cnt;
                    if (!above_thr) begin
                        state_nxt = S_ARMED;
                        cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = S_FLUSH;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counters and registered outputs. The status outputs are decoded
    // from state_nxt so they are glitch-free flops that track the state exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_FLUSH;
            cnt            <= '0;
            timestamp      <= '0;
            peak_data      <= '0;
            peak_time      <= '0;
            pileup_count   <= '0;
            filter_reset_n <= 1'b0;
            peak_valid     <= 1'b0;
            busy           <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the values
            // from before this edge regardless of statement order.
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            timestamp      <= timestamp + 16'd1;
            peak_data      <= max_nxt;
            peak_time      <= max_time_nxt;
            pileup_count   <= pileup_nxt;
            filter_reset_n <= (state_nxt != S_FLUSH);
            peak_valid     <= (state_nxt == S_EMIT);
            busy           <= (state_nxt != S_ARMED);
        end
    end

endmodule

// File: tb/tb_v3_peak_controller.sv
// -----------------------------------------------------------------------------
// tb_v3_peak_controller
//
// Directed-vector bench for v3_peak_controller. A phase-countdown model of the
// peak-capture rules predicts filter_reset_n, busy, peak_valid, pileup_count
// and the offered peak; a compare process checks them on every falling edge.
// Scenario code adds hand-computed literal checks on the transfers.
// -----------------------------------------------------------------------------
module tb_v3_peak_controller;

    localparam int W           = 12;
    localparam int FLUSH_LEN   = 4;
    localparam int SETTLE_LEN  = 8;
    localparam int MAX_RISE    = 64;
    localparam int HOLDOFF_LEN = 32;

    logic          clk         = 1'b0;
    logic          reset       = 1'b1;
    logic          enable      = 1'b0;
    logic [W-1:0]  threshold   = W'(100);
    logic [W-1:0]  filter_data = '0;
    logic          peak_ready  = 1'b0;
    logic          filter_reset_n;
    logic [W-1:0]  peak_data;
    logic [15:0]   peak_time;
    logic          peak_valid;
    logic [15:0]   pileup_count;
    logic          busy;

    v3_peak_controller #(
        .SIZE_ADC_DATA (W),
        .FLUSH_LEN     (FLUSH_LEN),
        .SETTLE_LEN    (SETTLE_LEN),
        .MAX_RISE      (MAX_RISE),
        .HOLDOFF_LEN   (HOLDOFF_LEN)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .threshold      (threshold),
        .filter_data    (filter_data),
        .filter_reset_n (filter_reset_n),
        .peak_data      (peak_data),
        .peak_time      (peak_time),
        .peak_valid     (peak_valid),
        .peak_ready     (peak_ready),
        .pileup_count   (pileup_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0]  m_ts;
    logic [15:0]  now_ts;
    int           flush_left;
    int           settle_left;
    int           rise_cycles;
    int           hold_cycles;
    int           pileups;
    bit           m_armed, m_rising, m_emitting, m_holding;
    logic [W-1:0] pk;
    logic [15:0]  pk_t;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_ts        = '0;
            flush_left  = FLUSH_LEN;
            settle_left = 0;
            rise_cycles = 0;
            hold_cycles = 0;
            pileups     = 0;
            m_armed     = 0;
            m_rising    = 0;
            m_emitting  = 0;
            m_holding   = 0;
            pk          = '0;
            pk_t        = '0;
        end else begin
            now_ts = m_ts;
            m_ts   = m_ts + 16'd1;
            if (flush_left > 0) begin
                flush_left--;
                if (flush_left == 0) settle_left = SETTLE_LEN;
            end else if (settle_left > 0) begin
                settle_left--;
                if (settle_left == 0) m_armed = 1;
            end else if (m_armed) begin
                if (enable && ($signed(filter_data) > $signed(threshold))) begin
                    m_armed     = 0;
                    m_rising    = 1;
                    pk          = filter_data;
                    pk_t        = now_ts;
                    rise_cycles = 0;
                end
            end else if (m_rising) begin
                rise_cycles++;
                if ($signed(filter_data) < $signed(pk)) begin
                    m_rising   = 0;
                    m_emitting = 1;
                end else if (rise_cycles == MAX_RISE) begin
                    m_rising   = 0;
                    if (pileups < 65535) pileups++;
                    flush_left = FLUSH_LEN;
                end else if ($signed(filter_data) > $signed(pk)) begin
                    pk   = filter_data;
                    pk_t = now_ts;
                end
            end else if (m_emitting) begin
                if (peak_ready) begin
                    m_emitting  = 0;
                    m_holding   = 1;
                    hold_cycles = 0;
                end
            end else if (m_holding) begin
                hold_cycles++;
                if (hold_cycles >= HOLDOFF_LEN && $signed(filter_data) <= $signed(threshold)) begin
                    m_holding = 0;
                    m_armed   = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int low_cnt = 0;

    initial forever begin
        @(negedge clk);
        check("filter_reset_n", filter_reset_n, (flush_left == 0));
        check("busy", busy, !m_armed);
        check("peak_valid", peak_valid, m_emitting);
        check("pileup_count", pileup_count, pileups[15:0]);
        if (reset) begin
            check("peak_data_in_reset", peak_data, 0);
            check("peak_time_in_reset", peak_time, 0);
        end else begin
            if (!filter_reset_n) low_cnt++;
            if (m_emitting) begin
                check("peak_data", peak_data, pk);
                check("peak_time", peak_time, pk_t);
            end
        end
    end

    // ---------------- transfer monitor ----------------
    int           n_xfer = 0;
    logic [W-1:0] xfer_data = '0;
    logic [15:0]  xfer_time = '0;

    initial forever begin
        @(posedge clk);
        if (!reset && peak_valid && peak_ready) begin
            n_xfer++;
            xfer_data = peak_data;
            xfer_time = peak_time;
        end
    end

    // ---------------- stimulus ----------------
    // stim_ts is the timestamp the next driven sample will be taken at.
    logic [15:0] stim_ts = '0;

    task automatic step();
        @(posedge clk);
        #1;
        stim_ts = stim_ts + 16'd1;
    endtask

    task automatic drive(input int v);
        filter_data = W'(v);
        step();
    endtask

    task automatic idle(input int n);
        filter_data = '0;
        repeat (n) step();
    endtask

    initial begin
        int           n0;
        logic [15:0]  t_pk;
        logic [W-1:0] e_val;

        // Reset state, sampled while reset is held.
        @(posedge clk);
        #1;
        check("rst_filter_reset_n", filter_reset_n, 0);
        check("rst_busy", busy, 1);
        check("rst_peak_valid", peak_valid, 0);
        check("rst_peak_data", peak_data, 0);
        check("rst_peak_time", peak_time, 0);
        check("rst_pileup", pileup_count, 0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        stim_ts = '0;
        low_cnt = 0;
        enable  = 1'b1;
        idle(FLUSH_LEN + SETTLE_LEN + 3);
        check("init_flush_low_cycles", low_cnt, FLUSH_LEN);
        check("init_armed", busy, 0);

        // Basic pulse with ready already high.
        peak_ready = 1'b1;
        n0 = n_xfer;
        drive(0); drive(50); drive(150); drive(300);
        t_pk = stim_ts;
        drive(450);
        check("basic_no_valid_before_drop", peak_valid, 0);
        drive(400);
        check("basic_valid_latency", peak_valid, 1);
        filter_data = '0;
        step();
        check("basic_xfer_count", n_xfer - n0, 1);
        check("basic_peak_data", xfer_data, 450);
        check("basic_peak_time", xfer_time, t_pk);
        check("basic_valid_drop", peak_valid, 0);
        check("basic_holdoff_busy", busy, 1);
        idle(40);

        // Backpressure: ready low for 10 cycles, filter_data ignored in EMIT.
        peak_ready = 1'b0;
        n0 = n_xfer;
        drive(0); drive(200); drive(600); drive(100);
        for (int i = 0; i < 10; i++) begin
            drive(1000);
            check("bp_valid_held", peak_valid, 1);
            check("bp_data_stable", peak_data, 600);
        end
        check("bp_no_xfer_yet", n_xfer - n0, 0);
        peak_ready = 1'b1;
        drive(0);
        check("bp_xfer_count", n_xfer - n0, 1);
        check("bp_peak_data", xfer_data, 600);
        check("bp_valid_drop", peak_valid, 0);
        idle(40);

        // Holdoff: tail stays above threshold, no retrigger until it drops.
        n0 = n_xfer;
        drive(0); drive(300); drive(200);
        for (int i = 0; i < HOLDOFF_LEN + 13; i++) drive(200);
        check("hold_one_event", n_xfer - n0, 1);
        check("hold_still_busy", busy, 1);
        drive(50);
        check("hold_rearmed", busy, 0);
        drive(300); drive(250);
        drive(0);
        check("hold_second_event", n_xfer - n0, 2);
        check("hold_second_data", xfer_data, 300);
        idle(40);

        // Enable gating and signed threshold behaviour.
        n0 = n_xfer;
        enable = 1'b0;
        drive(0); drive(200); drive(500); drive(300); drive(0);
        check("gate_no_event", n_xfer - n0, 0);
        check("gate_armed", busy, 0);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) drive(-500);
        check("neg_no_trigger", busy, 0);
        threshold = W'(-10);
        drive(-50); drive(-5); drive(-20);
        drive(-30);
        e_val = W'(-5);
        check("negthr_event", n_xfer - n0, 1);
        check("negthr_peak_data", xfer_data, e_val);
        threshold = W'(100);
        idle(40);

        // Pile-up: monotonic ramp for 70 cycles.
        n0 = n_xfer;
        low_cnt = 0;
        for (int i = 0; i < 70; i++) drive(150 + i);
        idle(20);
        check("pileup_count_one", pileup_count, 1);
        check("pileup_no_event", n_xfer - n0, 0);
        check("pileup_flush_low_cycles", low_cnt, FLUSH_LEN);
        check("pileup_rearmed", busy, 0);

        // Timestamp wrap with the peak on 0xFFFF.
        n0 = n_xfer;
        while (stim_ts != 16'hFFFD) step();
        drive(150); drive(300); drive(450); drive(400);
        filter_data = '0;
        step();
        check("wrap_event", n_xfer - n0, 1);
        check("wrap_peak_data", xfer_data, 450);
        check("wrap_peak_time", xfer_time, 16'hFFFF);
        idle(40);
        drive(150);
        t_pk = stim_ts;
        drive(200); drive(100);
        filter_data = '0;
        step();
        check("post_wrap_event", n_xfer - n0, 2);
        check("post_wrap_time", xfer_time, t_pk);
        check("post_wrap_small", xfer_time < 16'h0100, 1);
        idle(40);

        // Reset while a peak is being offered.
        peak_ready = 1'b0;
        n0 = n_xfer;
        drive(0); drive(150); drive(300); drive(200);
        check("mid_emit_valid", peak_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_emit_valid_cleared", peak_valid, 0);
        check("mid_emit_pileup_cleared", pileup_count, 0);
        check("mid_emit_filter_reset", filter_reset_n, 0);
        check("mid_emit_busy", busy, 1);
        peak_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b0;
        stim_ts = '0;
        low_cnt = 0;
        idle(20);
        check("reflush_low_cycles", low_cnt, FLUSH_LEN);
        check("reflush_no_xfer", n_xfer - n0, 0);
        check("reflush_armed", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
